// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control unit (lw, sw, R-type, beq, addi).
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   OP, Funct           opcode / function field from the instruction register
//   Zero                ALU zero flag from the datapath (qualifies PCWrite in BRANCH)
//   PCWrite .. ALUSrcA  single-bit datapath controls
//   ALUSrcB             SrcB select: 00 B, 01 4, 10 SignImm, 11 SignImm<<2
//   ALUControl          0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
//   State_o             current state encoding
//   Illegal_o           pulse in DECODE for an unsupported instruction
//   Instr_Count_o       retired-instruction counter (wraps)
module multicycle_control_unit #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic [5:0]             Funct,
  input  logic                   Zero,
  output logic                   PCWrite,
  output logic                   IorD,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   PCSrc,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [3:0]             ALUControl,
  output logic [3:0]             State_o,
  output logic                   Illegal_o,
  output logic [COUNT_WIDTH-1:0] Instr_Count_o
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t                 state_q, state_d;
  logic                   is_sw_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   funct_legal_c;
  logic [3:0]             funct_alu_c;
  logic                   decode_illegal_c;
  logic                   retire_c;

  // Funct field decode shared by DECODE legality and EXECUTE ALU select
  always_comb begin
    funct_legal_c = 1'b1;
    funct_alu_c   = ALU_ADD;
    case (Funct)
      FN_ADD:  funct_alu_c = ALU_ADD;
      FN_SUB:  funct_alu_c = ALU_SUB;
      FN_AND:  funct_alu_c = ALU_AND;
      FN_OR:   funct_alu_c = ALU_OR;
      FN_SLT:  funct_alu_c = ALU_SLT;
      default: funct_legal_c = 1'b0;
    endcase
  end

  assign decode_illegal_c = !((OP == OP_LW) || (OP == OP_SW) || (OP == OP_BEQ) ||
                              (OP == OP_ADDI) || ((OP == OP_RTYPE) && funct_legal_c));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // lw/sw choice captured in DECODE so OP is free to change afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     is_sw_q <= 1'b0;
    else if (state_q == S_DECODE)   is_sw_q <= (OP == OP_SW);
  end

  // Retire happens on the edge leaving the last state of each instruction
  assign retire_c = (state_q == S_MEMWB) || (state_q == S_MEMWR) || (state_q == S_ALUWB) ||
                    (state_q == S_BRANCH) || (state_q == S_ADDIWB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        count_q <= '0;
    else if (retire_c) count_q <= count_q + COUNT_WIDTH'(1);
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if ((OP == OP_LW) || (OP == OP_SW))           state_d = S_MEMADR;
        else if ((OP == OP_RTYPE) && funct_legal_c)   state_d = S_EXECUTE;
        else if (OP == OP_BEQ)                        state_d = S_BRANCH;
        else if (OP == OP_ADDI)                       state_d = S_ADDIEXEC;
        else                                          state_d = S_FETCH;
      end
      S_MEMADR:   state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; write enables and Illegal_o are held low during reset
  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    PCSrc      = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    Illegal_o  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        Illegal_o = decode_illegal_c;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu_c;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 1'b1;
        PCWrite    = Zero;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      PCWrite   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      Illegal_o = 1'b0;
    end
  end

  assign State_o       = state_q;
  assign Instr_Count_o = count_q;

endmodule
